// File: rtl/dff_resp_checker_pkg.sv
// Shared types for the D flip-flop response checker.
// Checker state encoding and capture widths.
package dff_resp_checker_pkg;

  localparam int STATE_W     = 2;
  localparam int CAP_CYCLE_W = 16;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    CHECK  = 2'd2,
    FAIL   = 2'd3
  } state_t;

endpackage

// File: rtl/dff_resp_model_pipe.sv
// Expected-q model: LATENCY-deep shift register of d.
// dut_reset flushes every stage to zero on the same edge.
module dff_resp_model_pipe #(
  parameter int WIDTH   = 1,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] exp_q
);

  logic [LATENCY-1:0][WIDTH-1:0] stage;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage <= '0;
    end else if (flush) begin
      stage <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < LATENCY; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign exp_q = stage[LATENCY-1];

endmodule

// File: rtl/dff_resp_checker.sv
// Response checker beside a D flip-flop: predicts q, checks qb == ~q.
// Optional first-mismatch capture: DFF_RESP_CHECKER_CAPTURE_EN.
module dff_resp_checker
  import dff_resp_checker_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int LATENCY     = 1,
  parameter int CNT_W       = 8,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               dut_reset,
  input  logic [WIDTH-1:0]   d,
  input  logic [WIDTH-1:0]   q,
  input  logic [WIDTH-1:0]   qb,
  input  logic               clear,
  output logic               err,
  output logic               err_pulse,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [CNT_W-1:0]   chk_cnt,
  output logic [STATE_W-1:0] state
`ifdef DFF_RESP_CHECKER_CAPTURE_EN
  ,
  output logic                   cap_valid,
  output logic [WIDTH-1:0]       cap_exp,
  output logic [WIDTH-1:0]       cap_q,
  output logic [WIDTH-1:0]       cap_qb,
  output logic [CAP_CYCLE_W-1:0] cap_cycle
`endif
);

  localparam int WCNT_W = $clog2(LATENCY + 1);
  localparam logic [WCNT_W-1:0] WLAST = WCNT_W'(LATENCY - 1);

  state_t            st;
  logic [WCNT_W-1:0] wcnt;
  logic [WIDTH-1:0]  exp_q;
  logic              check_en;
  logic              mismatch;
  logic              hit;

  dff_resp_model_pipe #(
    .WIDTH  (WIDTH),
    .LATENCY(LATENCY)
  ) u_pipe (
    .clk    (clk),
    .reset_n(reset_n),
    .flush  (dut_reset),
    .d      (d),
    .exp_q  (exp_q)
  );

  always_comb begin
    check_en = 1'b0;
    mismatch = 1'b0;
    hit      = 1'b0;
    check_en = (st == CHECK) && enable;
    mismatch = (q != exp_q) || (qb != ~q);
    hit      = check_en && mismatch && !clear;
  end

  assign state = st;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st        <= IDLE;
      wcnt      <= '0;
      err       <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
      chk_cnt   <= '0;
    end else begin
      err_pulse <= hit;
      // clear outranks a same-cycle mismatch
      if (clear) begin
        err     <= 1'b0;
        err_cnt <= '0;
        chk_cnt <= '0;
      end else if (check_en) begin
        chk_cnt <= (&chk_cnt) ? chk_cnt : chk_cnt + 1'b1;
        if (mismatch) begin
          err     <= 1'b1;
          err_cnt <= (&err_cnt) ? err_cnt : err_cnt + 1'b1;
        end
      end
      if (!enable) begin
        st <= IDLE;
      end else begin
        unique case (st)
          IDLE: begin
            st   <= WARMUP;
            wcnt <= '0;
          end
          WARMUP: begin
            if (wcnt == WLAST) st <= CHECK;
            else wcnt <= wcnt + 1'b1;
          end
          CHECK: begin
            if (hit && STOP_ON_ERR) st <= FAIL;
          end
          FAIL: begin
            if (clear) st <= CHECK;
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

`ifdef DFF_RESP_CHECKER_CAPTURE_EN
  logic [CAP_CYCLE_W-1:0] cyc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc       <= '0;
      cap_valid <= 1'b0;
      cap_exp   <= '0;
      cap_q     <= '0;
      cap_qb    <= '0;
      cap_cycle <= '0;
    end else if (clear) begin
      cyc       <= '0;
      cap_valid <= 1'b0;
      cap_exp   <= '0;
      cap_q     <= '0;
      cap_qb    <= '0;
      cap_cycle <= '0;
    end else if (check_en) begin
      cyc <= (&cyc) ? cyc : cyc + 1'b1;
      if (mismatch && !cap_valid) begin
        cap_valid <= 1'b1;
        cap_exp   <= exp_q;
        cap_q     <= q;
        cap_qb    <= qb;
        cap_cycle <= cyc;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dff_resp_checker.sv
// Directed bench for dff_resp_checker: main, stop-on-error
// and saturating (CNT_W=2) instances share one stimulus stream.
module tb_dff_resp_checker;
  import dff_resp_checker_pkg::*;

  logic clk = 1'b0;
  logic reset_n, enable, dut_reset, clear;
  logic [0:0] d, q, qb;

  logic m_err, m_pulse;
  logic [7:0] m_ecnt, m_ccnt;
  logic [1:0] m_st;
  logic s_err, s_pulse;
  logic [1:0] s_ecnt, s_ccnt, s_st;
  logic t_err, t_pulse;
  logic [1:0] t_ecnt, t_ccnt, t_st;

`ifdef DFF_RESP_CHECKER_CAPTURE_EN
  logic m_cv, s_cv, t_cv;
  logic [0:0] m_ce, m_cq, m_cqb, s_ce, s_cq, s_cqb, t_ce, t_cq, t_cqb;
  logic [15:0] m_cc, s_cc, t_cc;
`endif

  int total = 0;
  int bad = 0;
  int pulses = 0;
  logic fq = 1'b0;

  always #5 clk = ~clk;

  dff_resp_checker u_main (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .dut_reset(dut_reset), .d(d), .q(q), .qb(qb),
    .clear(clear), .err(m_err), .err_pulse(m_pulse),
    .err_cnt(m_ecnt), .chk_cnt(m_ccnt), .state(m_st)
`ifdef DFF_RESP_CHECKER_CAPTURE_EN
    , .cap_valid(m_cv), .cap_exp(m_ce), .cap_q(m_cq),
    .cap_qb(m_cqb), .cap_cycle(m_cc)
`endif
  );

  dff_resp_checker #(.CNT_W(2), .STOP_ON_ERR(1'b1)) u_stop (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .dut_reset(dut_reset), .d(d), .q(q), .qb(qb),
    .clear(clear), .err(s_err), .err_pulse(s_pulse),
    .err_cnt(s_ecnt), .chk_cnt(s_ccnt), .state(s_st)
`ifdef DFF_RESP_CHECKER_CAPTURE_EN
    , .cap_valid(s_cv), .cap_exp(s_ce), .cap_q(s_cq),
    .cap_qb(s_cqb), .cap_cycle(s_cc)
`endif
  );

  dff_resp_checker #(.CNT_W(2), .STOP_ON_ERR(1'b0)) u_sat (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .dut_reset(dut_reset), .d(d), .q(q), .qb(qb),
    .clear(clear), .err(t_err), .err_pulse(t_pulse),
    .err_cnt(t_ecnt), .chk_cnt(t_ccnt), .state(t_st)
`ifdef DFF_RESP_CHECKER_CAPTURE_EN
    , .cap_valid(t_cv), .cap_exp(t_ce), .cap_q(t_cq),
    .cap_qb(t_cqb), .cap_cycle(t_cc)
`endif
  );

  // Good flop: q shows the d sampled on the previous edge.
  task automatic tick(input logic dv, input logic rst);
    q = fq;
    qb = ~fq;
    d = dv;
    dut_reset = rst;
    fq = rst ? 1'b0 : dv;
    @(negedge clk);
    pulses += int'(m_pulse);
  endtask

  task automatic tick_raw(input logic dv, input logic qv, input logic qbv);
    q = qv;
    qb = qbv;
    d = dv;
    dut_reset = 1'b0;
    fq = dv;
    @(negedge clk);
    pulses += int'(m_pulse);
  endtask

  task automatic tick_clr(input logic dv);
    clear = 1'b1;
    tick(dv, 1'b0);
    clear = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; enable = 1'b0; clear = 1'b0;
    dut_reset = 1'b0; d = 1'b0; q = 1'b1; qb = 1'b0; fq = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (m_err !== 1'b0) begin bad++; $display("FAIL rst_err got %0d want 0", m_err); end
    total++; if (m_ecnt !== 8'd0) begin bad++; $display("FAIL rst_ecnt got %0d want 0", m_ecnt); end
    total++; if (m_ccnt !== 8'd0) begin bad++; $display("FAIL rst_ccnt got %0d want 0", m_ccnt); end
    total++; if (m_st !== IDLE) begin bad++; $display("FAIL rst_state got %0d want 0", m_st); end
    total++; if (m_pulse !== 1'b0) begin bad++; $display("FAIL rst_pulse got %0d want 0", m_pulse); end
    reset_n = 1'b1;
    enable = 1'b1;
    tick(1'b0, 1'b0);
    total++; if (m_st !== WARMUP) begin bad++; $display("FAIL warmup_state got %0d want 1", m_st); end
    tick(1'b0, 1'b0);
    total++; if (m_st !== CHECK) begin bad++; $display("FAIL check_state got %0d want 2", m_st); end
    total++; if (m_ccnt !== 8'd0) begin bad++; $display("FAIL check_ccnt0 got %0d want 0", m_ccnt); end
  endtask

  task automatic test_good;
    tick_clr(1'b0);
    pulses = 0;
    repeat (50) tick(1'($urandom_range(0, 1)), 1'b0);
    total++; if (m_err !== 1'b0) begin bad++; $display("FAIL good_err got %0d want 0", m_err); end
    total++; if (m_ecnt !== 8'd0) begin bad++; $display("FAIL good_ecnt got %0d want 0", m_ecnt); end
    total++; if (m_ccnt !== 8'd50) begin bad++; $display("FAIL good_ccnt got %0d want 50", m_ccnt); end
    total++; if (pulses !== 0) begin bad++; $display("FAIL good_pulses got %0d want 0", pulses); end
  endtask

  task automatic test_stuck;
    tick_clr(1'b0);
    tick(1'b1, 1'b0);
    pulses = 0;
    repeat (3) tick_raw(1'b1, 1'b0, 1'b1);
    total++; if (pulses !== 3) begin bad++; $display("FAIL stuck_pulses got %0d want 3", pulses); end
    total++; if (m_ecnt !== 8'd3) begin bad++; $display("FAIL stuck_ecnt got %0d want 3", m_ecnt); end
    total++; if (m_err !== 1'b1) begin bad++; $display("FAIL stuck_err got %0d want 1", m_err); end
    total++; if (m_ccnt !== 8'd4) begin bad++; $display("FAIL stuck_ccnt got %0d want 4", m_ccnt); end
    tick(1'b0, 1'b0);
    total++; if (m_err !== 1'b1) begin bad++; $display("FAIL stuck_sticky got %0d want 1", m_err); end
    total++; if (m_pulse !== 1'b0) begin bad++; $display("FAIL stuck_pulse_end got %0d want 0", m_pulse); end
    total++; if (m_ecnt !== 8'd3) begin bad++; $display("FAIL stuck_ecnt_hold got %0d want 3", m_ecnt); end
  endtask

  task automatic test_qb;
    tick_clr(1'b0);
    tick(1'b0, 1'b0);
    tick_raw(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0);
    total++; if (m_ecnt !== 8'd1) begin bad++; $display("FAIL qb_ecnt got %0d want 1", m_ecnt); end
    total++; if (m_err !== 1'b1) begin bad++; $display("FAIL qb_err got %0d want 1", m_err); end
    total++; if (m_ccnt !== 8'd3) begin bad++; $display("FAIL qb_ccnt got %0d want 3", m_ccnt); end
  endtask

  task automatic test_dut_reset;
    tick_clr(1'b0);
    pulses = 0;
    tick(1'b1, 1'b0);
    repeat (3) tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    total++; if (m_ecnt !== 8'd0) begin bad++; $display("FAIL drst_ecnt got %0d want 0", m_ecnt); end
    total++; if (m_err !== 1'b0) begin bad++; $display("FAIL drst_err got %0d want 0", m_err); end
    total++; if (pulses !== 0) begin bad++; $display("FAIL drst_pulses got %0d want 0", pulses); end
    total++; if (m_ccnt !== 8'd7) begin bad++; $display("FAIL drst_ccnt got %0d want 7", m_ccnt); end
  endtask

  task automatic test_enable_drop;
    tick_clr(1'b0);
    tick(1'b1, 1'b0);
    enable = 1'b0;
    tick_raw(1'b1, 1'b0, 1'b1);
    total++; if (m_st !== IDLE) begin bad++; $display("FAIL en_state got %0d want 0", m_st); end
    total++; if (m_ecnt !== 8'd0) begin bad++; $display("FAIL en_ecnt got %0d want 0", m_ecnt); end
    total++; if (m_err !== 1'b0) begin bad++; $display("FAIL en_err got %0d want 0", m_err); end
    total++; if (m_ccnt !== 8'd1) begin bad++; $display("FAIL en_ccnt got %0d want 1", m_ccnt); end
    total++; if (m_pulse !== 1'b0) begin bad++; $display("FAIL en_pulse got %0d want 0", m_pulse); end
    enable = 1'b1;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    total++; if (m_st !== CHECK) begin bad++; $display("FAIL en_rearm got %0d want 2", m_st); end
    total++; if (m_ccnt !== 8'd1) begin bad++; $display("FAIL en_ccnt_hold got %0d want 1", m_ccnt); end
  endtask

  task automatic test_clear_vs_mismatch;
    tick(1'b1, 1'b0);
    clear = 1'b1;
    tick_raw(1'b1, 1'b0, 1'b1);
    clear = 1'b0;
    total++; if (m_err !== 1'b0) begin bad++; $display("FAIL clr_err got %0d want 0", m_err); end
    total++; if (m_ecnt !== 8'd0) begin bad++; $display("FAIL clr_ecnt got %0d want 0", m_ecnt); end
    total++; if (m_ccnt !== 8'd0) begin bad++; $display("FAIL clr_ccnt got %0d want 0", m_ccnt); end
    total++; if (m_pulse !== 1'b0) begin bad++; $display("FAIL clr_pulse got %0d want 0", m_pulse); end
  endtask

  task automatic test_stop_sat;
    tick_clr(1'b1);
    repeat (5) tick_raw(1'b1, 1'b0, 1'b1);
    total++; if (s_st !== FAIL) begin bad++; $display("FAIL stop_state got %0d want 3", s_st); end
    total++; if (s_ecnt !== 2'd1) begin bad++; $display("FAIL stop_ecnt got %0d want 1", s_ecnt); end
    total++; if (s_ccnt !== 2'd1) begin bad++; $display("FAIL stop_ccnt got %0d want 1", s_ccnt); end
    total++; if (s_err !== 1'b1) begin bad++; $display("FAIL stop_err got %0d want 1", s_err); end
    total++; if (t_ecnt !== 2'd3) begin bad++; $display("FAIL sat_ecnt got %0d want 3", t_ecnt); end
    total++; if (t_ccnt !== 2'd3) begin bad++; $display("FAIL sat_ccnt got %0d want 3", t_ccnt); end
    total++; if (t_st !== CHECK) begin bad++; $display("FAIL sat_state got %0d want 2", t_st); end
    total++; if (m_ecnt !== 8'd5) begin bad++; $display("FAIL main_ecnt5 got %0d want 5", m_ecnt); end
    tick_clr(1'b1);
    total++; if (s_st !== CHECK) begin bad++; $display("FAIL stop_clr_state got %0d want 2", s_st); end
    total++; if (s_ecnt !== 2'd0) begin bad++; $display("FAIL stop_clr_ecnt got %0d want 0", s_ecnt); end
    total++; if (s_ccnt !== 2'd0) begin bad++; $display("FAIL stop_clr_ccnt got %0d want 0", s_ccnt); end
    total++; if (s_err !== 1'b0) begin bad++; $display("FAIL stop_clr_err got %0d want 0", s_err); end
  endtask

  initial begin
    test_reset();
    test_good();
    test_stuck();
    test_qb();
    test_dut_reset();
    test_enable_drop();
    test_clear_vs_mismatch();
    test_stop_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
